// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the wait-state Avalon-MM RAM used under the CPU bench.
package mips_avalon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } ram_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic [1:0] {
        AV_RESP_OKAY        = 2'b00,
        AV_RESP_RESERVED    = 2'b01,
        AV_RESP_SLVERR      = 2'b10,
        AV_RESP_DECODEERROR = 2'b11
    } avalon_resp_t;

    // Evaluated in 33 bits so a region ending exactly at 2^32 cannot wrap.
    function automatic logic addr_in_region(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned words);
        logic [32:0] lim;
        lim = {1'b0, base} + (33'(words) << 2);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/mips_avalon_ram_ws_if.sv
// Avalon-MM word port between the CPU bus master and the wait-state RAM.
interface mips_avalon_ram_ws_if;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] writedata;

    // Master holds address/read/write/byteenable/writedata while waitrequest is high;
    // a transfer completes in the cycle where read|write is high and waitrequest is low.
    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_wait_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying pseudo-random wait-state counts.
module mips_wait_lfsr (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    // Maximal-length polynomial; a non-zero seed never reaches the all-zero lockup state.
    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= seed;
        end else if (step) begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/mips_avalon_ram_ws.sv
// Avalon-MM slave RAM with instruction and data regions, inserting fixed or LFSR-driven
// wait states so the CPU's stall handling gets exercised.
module mips_avalon_ram_ws
    import mips_avalon_pkg::*;
#(
    parameter string       RAM_INIT_FILE  = "",
    parameter string       DATA_INIT_FILE = "",
    parameter logic [31:0] INSTR_BASE     = RESET_VECTOR,
    parameter int unsigned INSTR_WORDS    = 1024,
    parameter logic [31:0] DATA_BASE      = 32'h00001000,
    parameter int unsigned DATA_WORDS     = 1024,
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter bit          RANDOM_WAIT    = 1'b0,
    parameter int unsigned MAX_WAIT       = 7,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5,
    parameter bit          REPORT_ERRORS  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_avalon_ram_ws_if.slave   bus,
    output ram_state_t            o_dbg_state,
    output logic [7:0]            o_dbg_wait_cnt,
    output logic [7:0]            o_dbg_lfsr,
    output logic                  o_dbg_addr_err,
    output avalon_resp_t          o_dbg_resp
);

    localparam int IW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
    localparam int DW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [7:0] L_MAX_WAIT = 8'(MAX_WAIT);
    localparam logic [7:0] L_FIX_WAIT = 8'(WAIT_CYCLES);

    ram_state_t  r_state;
    ram_state_t  w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [7:0]  w_n;
    logic [7:0]  w_lfsr;
    logic        w_step;
    logic        w_req;
    logic        w_enter_ready;

    logic [31:0] r_imem [INSTR_WORDS];
    logic [31:0] r_dmem [DATA_WORDS];
    logic [31:0] r_readdata;

    logic        w_aligned;
    logic        w_hit_instr;
    logic        w_hit_data;
    logic        w_addr_ok;
    logic [IW-1:0] w_i_idx;
    logic [DW-1:0] w_d_idx;
    logic [31:0] w_rdata;
    logic        w_commit_wr;
    logic [31:0] w_lane_mask;

    logic [31:0] r_req_addr;
    logic        r_req_rd;
    logic        r_req_wr;

    assign w_req = bus.read | bus.write;

    mips_wait_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (w_step),
        .seed  (LFSR_SEED),
        .value (w_lfsr)
    );

    // ---------------- handshake FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_step       = 1'b0;
        w_n          = RANDOM_WAIT ? (w_lfsr & L_MAX_WAIT) : L_FIX_WAIT;
        unique case (r_state)
            IDLE: begin
                if (w_req && !reset) begin
                    w_step = 1'b1;
                    if (w_n == 8'd0) begin
                        w_state_next = READY;
                    end else begin
                        w_cnt_next   = w_n - 8'd1;
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = READY;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            READY: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.waitrequest = reset | (w_req & (r_state != READY));
    assign w_enter_ready   = (r_state != READY) && (w_state_next == READY);

    // ---------------- address decode ----------------
    assign w_aligned   = (bus.address[1:0] == 2'b00);
    assign w_hit_instr = addr_in_region(bus.address, INSTR_BASE, INSTR_WORDS);
    assign w_hit_data  = !w_hit_instr && addr_in_region(bus.address, DATA_BASE, DATA_WORDS);
    assign w_addr_ok   = w_aligned && (w_hit_instr || w_hit_data);
    assign w_i_idx     = IW'((bus.address - INSTR_BASE) >> 2);
    assign w_d_idx     = DW'((bus.address - DATA_BASE) >> 2);

    always_comb begin
        w_rdata = 32'h0;
        if (w_addr_ok) begin
            w_rdata = w_hit_instr ? r_imem[w_i_idx] : r_dmem[w_d_idx];
        end
    end

    // ---------------- read data ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 32'h0;
        end else if (w_enter_ready && bus.read) begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;

    // ---------------- write commit ----------------
    // Writes land on the edge that leaves READY; a reset on that edge drops them.
    assign w_commit_wr = !reset && (r_state == READY) && bus.write && w_addr_ok;
    assign w_lane_mask = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                          {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};

    always_ff @(posedge clk) begin
        if (w_commit_wr && w_hit_instr) begin
            r_imem[w_i_idx] <= (r_imem[w_i_idx] & ~w_lane_mask) | (bus.writedata & w_lane_mask);
        end
        if (w_commit_wr && w_hit_data) begin
            r_dmem[w_d_idx] <= (r_dmem[w_d_idx] & ~w_lane_mask) | (bus.writedata & w_lane_mask);
        end
    end

    // ---------------- protocol checks (simulation only) ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_addr <= 32'h0;
            r_req_rd   <= 1'b0;
            r_req_wr   <= 1'b0;
        end else if (r_state == IDLE && w_req) begin
            r_req_addr <= bus.address;
            r_req_rd   <= bus.read;
            r_req_wr   <= bus.write;
        end
    end

    always_ff @(posedge clk) begin
        if (REPORT_ERRORS && !reset) begin
            if (r_state == IDLE && w_req) begin
                assert (!(bus.read && bus.write))
                    else $fatal(1, "mips_avalon_ram_ws: read and write both high at %h", bus.address);
                assert (w_addr_ok)
                    else $error("mips_avalon_ram_ws: misaligned or unmapped address %h", bus.address);
            end
            if (r_state != IDLE) begin
                assert (bus.address == r_req_addr && bus.read == r_req_rd && bus.write == r_req_wr)
                    else $error("mips_avalon_ram_ws: request changed while waitrequest was high");
            end
        end
    end

    assign o_dbg_state    = r_state;
    assign o_dbg_wait_cnt = r_cnt;
    assign o_dbg_lfsr     = w_lfsr;
    assign o_dbg_addr_err = w_req && !w_addr_ok;
    assign o_dbg_resp     = (w_req && !w_addr_ok) ? AV_RESP_DECODEERROR : AV_RESP_OKAY;

endmodule

// File: tb/tb_mips_avalon_ram_ws.sv
// Bench for mips_avalon_ram_ws: fixed-wait, zero-wait and random-wait instances behind one driver.
module tb_mips_avalon_ram_ws;
    import mips_avalon_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared master signals ----------------
    int          sel = 0;
    logic [31:0] m_addr = 32'h0;
    logic [3:0]  m_be   = 4'h0;
    logic [31:0] m_wd   = 32'h0;
    logic        m_rd   = 1'b0;
    logic        m_wr   = 1'b0;

    mips_avalon_ram_ws_if bus_fix ();
    mips_avalon_ram_ws_if bus_zero ();
    mips_avalon_ram_ws_if bus_rnd ();

    assign bus_fix.address     = m_addr;
    assign bus_fix.byteenable  = m_be;
    assign bus_fix.writedata   = m_wd;
    assign bus_fix.read        = m_rd && (sel == 0);
    assign bus_fix.write       = m_wr && (sel == 0);
    assign bus_zero.address    = m_addr;
    assign bus_zero.byteenable = m_be;
    assign bus_zero.writedata  = m_wd;
    assign bus_zero.read       = m_rd && (sel == 1);
    assign bus_zero.write      = m_wr && (sel == 1);
    assign bus_rnd.address     = m_addr;
    assign bus_rnd.byteenable  = m_be;
    assign bus_rnd.writedata   = m_wd;
    assign bus_rnd.read        = m_rd && (sel == 2);
    assign bus_rnd.write       = m_wr && (sel == 2);

    ram_state_t   st_fix, st_zero, st_rnd;
    logic [7:0]   cnt_fix, cnt_zero, cnt_rnd;
    logic [7:0]   lfsr_fix, lfsr_zero, lfsr_rnd;
    logic         err_fix, err_zero, err_rnd;
    avalon_resp_t resp_fix, resp_zero, resp_rnd;

    mips_avalon_ram_ws #(.WAIT_CYCLES(2), .RANDOM_WAIT(1'b0), .REPORT_ERRORS(1'b0)) u_fix (
        .clk(clk), .reset(rst), .bus(bus_fix.slave),
        .o_dbg_state(st_fix), .o_dbg_wait_cnt(cnt_fix), .o_dbg_lfsr(lfsr_fix),
        .o_dbg_addr_err(err_fix), .o_dbg_resp(resp_fix));

    mips_avalon_ram_ws #(.WAIT_CYCLES(0), .RANDOM_WAIT(1'b0), .REPORT_ERRORS(1'b0)) u_zero (
        .clk(clk), .reset(rst), .bus(bus_zero.slave),
        .o_dbg_state(st_zero), .o_dbg_wait_cnt(cnt_zero), .o_dbg_lfsr(lfsr_zero),
        .o_dbg_addr_err(err_zero), .o_dbg_resp(resp_zero));

    mips_avalon_ram_ws #(.RANDOM_WAIT(1'b1), .MAX_WAIT(7), .LFSR_SEED(8'hA5), .REPORT_ERRORS(1'b0)) u_rnd (
        .clk(clk), .reset(rst), .bus(bus_rnd.slave),
        .o_dbg_state(st_rnd), .o_dbg_wait_cnt(cnt_rnd), .o_dbg_lfsr(lfsr_rnd),
        .o_dbg_addr_err(err_rnd), .o_dbg_resp(resp_rnd));

    logic       s_wait;
    logic [31:0] s_rdata;
    logic       s_err;
    ram_state_t s_state;
    assign s_wait  = (sel == 0) ? bus_fix.waitrequest : (sel == 1) ? bus_zero.waitrequest : bus_rnd.waitrequest;
    assign s_rdata = (sel == 0) ? bus_fix.readdata : (sel == 1) ? bus_zero.readdata : bus_rnd.readdata;
    assign s_err   = (sel == 0) ? err_fix : (sel == 1) ? err_zero : err_rnd;
    assign s_state = (sel == 0) ? st_fix : (sel == 1) ? st_zero : st_rnd;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl_mem [logic [31:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return (a % 4 == 0) &&
               ((a >= 32'hBFC00000 && a < 32'hBFC00000 + 4 * 1024) ||
                (a >= 32'h00001000 && a < 32'h00001000 + 4 * 1024));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r = (r & ~(32'hFF << (8 * b))) | (wd & (32'hFF << (8 * b)));
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    logic [31:0] x_rdata;
    int          x_waits;
    logic        x_done;
    logic        x_err;

    // Called at a falling edge; returns at a falling edge with the request dropped.
    task automatic xfer(input logic is_wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        m_addr = a; m_be = be; m_wd = wd; m_rd = !is_wr; m_wr = is_wr;
        x_waits = 0; x_done = 1'b0; x_rdata = 32'h0;
        #1;
        x_err = s_err;
        for (int c = 0; c < 64 && !x_done; c++) begin
            if (s_wait) begin
                x_waits++;
                @(negedge clk);
                #1;
            end else begin
                x_done  = 1'b1;
                x_rdata = s_rdata;
            end
        end
        check_eq("handshake_done", 32'(x_done), 32'd1);
        @(negedge clk);
        m_rd = 1'b0; m_wr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int w_min, w_max, w;
    logic [31:0] a, wd, prev_rd;
    logic [3:0]  be;
    logic        is_wr;

    initial begin
        // Reset state
        sel = 0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_waitreq", 32'(s_wait), 32'd1);
        check_eq("rst_readdata", s_rdata, 32'h0);
        check_eq("rst_state", 32'(s_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle_waitreq_low", 32'(s_wait), 32'd0);
        @(negedge clk);

        // Fixed N=2: reset-vector word
        xfer(1'b1, 32'hBFC00000, 4'hF, 32'h24020005);
        check_eq("wr_vec_waits", 32'(x_waits), 32'd3);
        check_eq("wr_vec_err", 32'(x_err), 32'd0);
        xfer(1'b0, 32'hBFC00000, 4'h0, 32'h0);
        check_eq("rd_vec_waits", 32'(x_waits), 32'd3);
        check_eq("rd_vec_data", x_rdata, 32'h24020005);
        #1;
        check_eq("rd_hold_idle", s_rdata, 32'h24020005);

        // Byte-lane write
        xfer(1'b1, 32'h00001004, 4'hF, 32'h11223344);
        check_eq("rd_hold_after_wr", x_rdata, 32'h24020005);
        xfer(1'b1, 32'h00001004, 4'b0101, 32'hAABBCCDD);
        xfer(1'b0, 32'h00001004, 4'h0, 32'h0);
        check_eq("be0101_data", x_rdata, 32'h11BB33DD);
        xfer(1'b1, 32'h00001004, 4'b0000, 32'hFFFFFFFF);
        check_eq("be0000_waits", 32'(x_waits), 32'd3);
        xfer(1'b0, 32'h00001004, 4'h0, 32'h0);
        check_eq("be0000_nochange", x_rdata, 32'h11BB33DD);

        // Region boundaries: top words valid, base+4*WORDS unmapped
        xfer(1'b1, 32'hBFC00FFC, 4'hF, 32'h0BADCAFE);
        xfer(1'b1, 32'h00001FFC, 4'hF, 32'h5EED5EED);
        xfer(1'b1, 32'h00002000, 4'hF, 32'h77777777);
        check_eq("oob_wr_err", 32'(x_err), 32'd1);
        xfer(1'b0, 32'hBFC00FFC, 4'h0, 32'h0);
        check_eq("instr_top_data", x_rdata, 32'h0BADCAFE);
        xfer(1'b0, 32'h00001FFC, 4'h0, 32'h0);
        check_eq("data_top_data", x_rdata, 32'h5EED5EED);
        xfer(1'b0, 32'h00002000, 4'h0, 32'h0);
        check_eq("oob_rd_data", x_rdata, 32'h0);
        check_eq("oob_rd_waits", 32'(x_waits), 32'd3);

        // Misaligned and unmapped reads
        xfer(1'b0, 32'h00001004, 4'h0, 32'h0);
        xfer(1'b0, 32'h00001002, 4'h0, 32'h0);
        check_eq("misalign_err", 32'(x_err), 32'd1);
        check_eq("misalign_data", x_rdata, 32'h0);
        check_eq("misalign_waits", 32'(x_waits), 32'd3);
        xfer(1'b0, 32'h00001004, 4'h0, 32'h0);
        xfer(1'b0, 32'h00005000, 4'h0, 32'h0);
        check_eq("unmapped_err", 32'(x_err), 32'd1);
        check_eq("unmapped_data", x_rdata, 32'h0);

        // Reset during WAIT of a write
        xfer(1'b1, 32'h00001008, 4'hF, 32'hCAFEF00D);
        xfer(1'b0, 32'h00001004, 4'h0, 32'h0);
        m_addr = 32'h00001008; m_be = 4'hF; m_wd = 32'hDEADBEEF; m_wr = 1'b1;
        @(negedge clk);
        check_eq("abort_in_wait_state", 32'(s_state), 32'(WAIT));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("abort_waitreq", 32'(s_wait), 32'd1);
        check_eq("abort_readdata", s_rdata, 32'h0);
        check_eq("abort_state", 32'(s_state), 32'(IDLE));
        m_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, 32'h00001008, 4'h0, 32'h0);
        check_eq("abort_wait_old", x_rdata, 32'hCAFEF00D);

        // Reset on the edge that would commit the write (READY cycle)
        m_addr = 32'h00001008; m_be = 4'hF; m_wd = 32'h12345678; m_wr = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("ready_cycle_low", 32'(s_wait), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        m_wr = 1'b0;
        rst = 1'b0;
        xfer(1'b0, 32'h00001008, 4'h0, 32'h0);
        check_eq("abort_ready_old", x_rdata, 32'hCAFEF00D);

        // N=0 back-to-back
        sel = 1;
        xfer(1'b1, 32'h00001000, 4'hF, 32'hA0A0A0A0);
        check_eq("n0_wr_waits", 32'(x_waits), 32'd1);
        xfer(1'b1, 32'h00001004, 4'hF, 32'hB1B1B1B1);
        xfer(1'b0, 32'h00001000, 4'h0, 32'h0);
        check_eq("n0_rd0_waits", 32'(x_waits), 32'd1);
        check_eq("n0_rd0_data", x_rdata, 32'hA0A0A0A0);
        xfer(1'b0, 32'h00001004, 4'h0, 32'h0);
        check_eq("n0_rd1_waits", 32'(x_waits), 32'd1);
        check_eq("n0_rd1_data", x_rdata, 32'hB1B1B1B1);

        // Random wait states vs scoreboard
        sel = 2;
        for (int i = 0; i < 12; i++) begin
            a  = (i < 8) ? 32'h00001000 + 32'(i * 4) : 32'hBFC00000 + 32'((i - 8) * 4);
            wd = $urandom;
            xfer(1'b1, a, 4'hF, wd);
            mdl_mem[a] = wd;
        end
        w_min = 1000; w_max = -1;
        for (int k = 0; k < 200; k++) begin
            w  = $urandom_range(0, 11);
            a  = (w < 8) ? 32'h00001000 + 32'(w * 4) : 32'hBFC00000 + 32'((w - 8) * 4);
            if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 1) ? (a | 32'h2) : 32'h00003000;
            is_wr = 1'($urandom_range(0, 1));
            be    = 4'($urandom_range(0, 15));
            wd    = $urandom;
            if (is_wr) begin
                xfer(1'b1, a, be, wd);
                if (addr_ok(a)) mdl_mem[a] = merge(mdl_mem[a], wd, be);
            end else begin
                exp_q.push_back(addr_ok(a) ? mdl_mem[a] : 32'h0);
                xfer(1'b0, a, 4'h0, 32'h0);
                prev_rd = exp_q.pop_front();
                check_eq("rnd_rdata", x_rdata, prev_rd);
            end
            check_eq("rnd_err_flag", 32'(x_err), 32'(!addr_ok(a)));
            check_eq("rnd_wait_bound", 32'(x_waits >= 1 && x_waits <= 8), 32'd1);
            if (x_waits < w_min) w_min = x_waits;
            if (x_waits > w_max) w_max = x_waits;
        end
        check_eq("rnd_wait_varies", 32'(w_max > w_min), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
